fft_input_loader: RTL

- Sequencer in front of the FFT core. Accepts a stream of 16-bit real samples over a valid/ready handshake.
- Writes samples into two ping-pong input RAM banks (A/B) and hands each completed frame to fft_control with a one-cycle start pulse.
- Tracks bank ownership: a full bank stays locked until the core signals completion, then returns to the filler.
- Sits between the sample source and fft_control/input RAMs in fft_top.

---
 rtl/fft_input_loader_if.sv | 29 ++
 rtl/fft_input_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fft_input_loader_if.sv
// Sample-side and core-side signals of fft_input_loader, bundled for port use.
// master: the environment (sample source + fft_control + input RAMs).
// slave : the loader itself.
interface fft_input_loader_if #(
  parameter int N_LOG2 = 10,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] iDATA;
  logic              iVALID;
  logic              oREADY;
  logic              iFFT_RDY;
  logic              oSTART;
  logic              oBANK_SEL;
  logic [N_LOG2-1:0] oWR_ADDR;
  logic [DATA_W-1:0] oWR_DATA;
  logic              oWE_A;
  logic              oWE_B;
  logic [1:0]        oFULL;

  modport master (
    output iDATA, iVALID, iFFT_RDY,
    input  oREADY, oSTART, oBANK_SEL, oWR_ADDR, oWR_DATA, oWE_A, oWE_B, oFULL
  );

  modport slave (
    input  iDATA, iVALID, iFFT_RDY,
    output oREADY, oSTART, oBANK_SEL, oWR_ADDR, oWR_DATA, oWE_A, oWE_B, oFULL
  );
endinterface

// File: rtl/fft_input_loader.sv
// fft_input_loader: fills two ping-pong input RAM banks from a valid/ready
// sample stream and hands each full frame to fft_control with a start pulse.
// A full bank stays locked until the core reports completion (iFFT_RDY rise).
// Optional build macro FFT_LOADER_DIGITREV_EN: write addresses are the base-4
// digit reversal of the sample index (in-place radix-4 DIT input order);
// otherwise samples are written in natural order.
// N_LOG2 must be even.
module fft_input_loader #(
  parameter int N_LOG2 = 10,
  parameter int DATA_W = 16
) (
  input logic               iCLK,
  input logic               iRESET,
  fft_input_loader_if.slave bus
);

  localparam int DIGITS = N_LOG2 / 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_ACK, S_RUN} state_t;

  logic [N_LOG2-1:0] cnt;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic              rdy_en;
  logic              accept;
  logic              last;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;
  logic              start;
  logic              release_bank;
  state_t            state;
  state_t            state_nxt;

  // Map a sample index to its RAM address.
  function automatic logic [N_LOG2-1:0] addr_of(input logic [N_LOG2-1:0] idx);
`ifdef FFT_LOADER_DIGITREV_EN
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[2*(DIGITS-1-d) +: 2] = idx[2*d +: 2];
    end
    return r;
`else
    return idx;
`endif
  endfunction

  // rdy_en keeps oREADY low until the first clock after reset release.
  assign bus.oREADY   = rdy_en & ~full[wr_bank];
  assign accept       = bus.iVALID & bus.oREADY;
  assign last         = (cnt == '1);
  assign set_mask     = (accept && last) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask     = release_bank ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  assign bus.oSTART   = start;
  assign bus.oBANK_SEL = rd_bank;
  assign bus.oFULL    = full;

  // Sample counter and fill-bank pointer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      cnt     <= '0;
      wr_bank <= 1'b0;
      rdy_en  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (last) wr_bank <= ~wr_bank;
      end
    end
  end

  // Registered RAM write port, one cycle behind the accept.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      bus.oWE_A    <= 1'b0;
      bus.oWE_B    <= 1'b0;
      bus.oWR_ADDR <= '0;
      bus.oWR_DATA <= '0;
    end else begin
      bus.oWE_A <= accept & ~wr_bank;
      bus.oWE_B <= accept & wr_bank;
      if (accept) begin
        bus.oWR_ADDR <= addr_of(cnt);
        bus.oWR_DATA <= bus.iDATA;
      end
    end
  end

  // Bank ownership: filler sets, FSM clears; the two never target one bank.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      full    <= 2'b00;
      rd_bank <= 1'b0;
      state   <= S_IDLE;
    end else begin
      full  <= (full | set_mask) & ~clr_mask;
      state <= state_nxt;
      if (release_bank) rd_bank <= ~rd_bank;
    end
  end

  // Start FSM: launch a full bank, wait for the core to take it, then finish.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    release_bank = 1'b0;
    unique case (state)
      S_IDLE:  if (full[rd_bank] && bus.iFFT_RDY) state_nxt = S_START;
      S_START: begin
        start     = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK:   if (!bus.iFFT_RDY) state_nxt = S_RUN;
      S_RUN:   if (bus.iFFT_RDY) begin
        release_bank = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
